// File: rtl/axi4lite_controller.sv
// Single-outstanding AXI4-Lite manager: one processor read/write request at a time, axi_ready pulses on completion.
// Zero-wait latency is 3 cycles from the request edge; every slave wait cycle stretches the current state by one.
module axi4lite_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        axi_valid,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        axi_ready,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RADDR = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        aw_done;
  logic        w_done;
  logic        aw_ok;
  logic        w_ok;

  // A channel counts as done once accepted, whether in an earlier cycle or on this edge.
  assign aw_ok = aw_done | awready;
  assign w_ok  = w_done  | wready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      mem_rdata <= 32'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (axi_valid) begin
            addr_q  <= mem_address;
            wdata_q <= mem_wdata;
            state   <= mem_wr_req ? WRITE : RADDR;
          end
        end
        RADDR: if (arready) state <= RDATA;
        RDATA: begin
          if (rvalid) begin
            mem_rdata <= rdata;
            state     <= DONE;
          end
        end
        WRITE: begin
          if (aw_ok && w_ok) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WRESP;
          end else begin
            aw_done <= aw_ok;
            w_done  <= w_ok;
          end
        end
        WRESP:   if (bvalid) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign arvalid   = (state == RADDR);
  assign rready    = (state == RDATA);
  assign awvalid   = (state == WRITE) && !aw_done;
  assign wvalid    = (state == WRITE) && !w_done;
  assign bready    = (state == WRESP);
  assign axi_ready = (state == DONE);
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_axi4lite_controller.sv
// Randomised bench for axi4lite_controller: reference memory predicts each completion, a slave model reports what crossed the bus.
module tb_axi4lite_controller;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        axi_valid;
  logic        mem_wr_req;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        axi_ready;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic        bvalid, bready;

  int checks = 0;
  int failures = 0;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] cur_addr = 0;
  logic [31:0] cur_wdata = 0;
  logic [31:0] last_rd = 0;
  int ar_d = -1, r_d = -1, aw_d = -1, w_d = -1, b_d = -1;

  axi4lite_controller dut (
    .clk(clk), .reset(reset), .axi_valid(axi_valid), .mem_wr_req(mem_wr_req),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .axi_ready(axi_ready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] srd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : fill(a);
  endfunction

  function automatic int pick(input int d);
    return (d < 0) ? int'($urandom_range(0, 4)) : d;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_axi_ready"}, axi_ready, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
  endtask

  // Called at a negedge; returns at the negedge of the cycle where axi_ready is seen.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input int lat);
    txn_t t;
    int n;
    t.wr   = wr;
    t.addr = a;
    t.data = wr ? d : (ref_mem.exists(a) ? ref_mem[a] : fill(a));
    if (wr) ref_mem[a] = d;
    exp_q.push_back(t);
    cur_addr    = a;
    cur_wdata   = d;
    axi_valid   = 1;
    mem_wr_req  = wr;
    mem_address = a;
    mem_wdata   = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!axi_ready && n < 200);
    if (!axi_ready) fail("request_timeout");
    else if (lat >= 0) chk("latency", n, lat);
  endtask

  task automatic idle();
    axi_valid = 0;
    @(negedge clk);
  endtask

  // Completion monitor: each axi_ready pulse consumes one predicted and one observed transaction.
  logic prev_rdy = 0;
  txn_t me, mo;
  always @(negedge clk) begin
    if (reset) begin
      if (axi_ready) begin
        chk("ready_one_cycle", prev_rdy, 0);
        if (exp_q.size() == 0 || obs_q.size() == 0) begin
          fail("unexpected_axi_ready");
        end else begin
          me = exp_q.pop_front();
          mo = obs_q.pop_front();
          chk("bus_kind", mo.wr, me.wr);
          chk("bus_addr", mo.addr, me.addr);
          chk("bus_data", mo.data, me.data);
          if (me.wr) chk("mem_rdata_kept", mem_rdata, last_rd);
          else begin
            chk("mem_rdata", mem_rdata, me.data);
            last_rd = me.data;
          end
        end
      end
      prev_rdy = axi_ready;
    end else begin
      prev_rdy = 0;
    end
  end

  // Slave model with per-channel delays (negative = random 0..4).
  initial begin : slave
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit ar_p, r_p, aw_p, w_p, b_p;
    bit ar_a, r_a, aw_a, w_a, b_a;
    int ar_c, r_c, aw_c, w_c, b_c;
    logic [31:0] ar_seen, aw_seen, w_seen;
    ar_a = 0; r_a = 0; aw_a = 0; w_a = 0; b_a = 0;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    ar_seen = 0; aw_seen = 0; w_seen = 0;
    arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(posedge clk);
      ar_hs = reset && arvalid && arready;
      r_hs  = reset && rready && rvalid;
      aw_hs = reset && awvalid && awready;
      w_hs  = reset && wvalid && wready;
      b_hs  = reset && bready && bvalid;
      ar_p  = reset && arvalid && !arready;
      r_p   = reset && rready && !rvalid;
      aw_p  = reset && awvalid && !awready;
      w_p   = reset && wvalid && !wready;
      b_p   = reset && bready && !bvalid;
      if (reset && arvalid) chk("araddr_stable", araddr, cur_addr);
      if (reset && awvalid) chk("awaddr_stable", awaddr, cur_addr);
      if (reset && wvalid)  chk("wdata_stable", wdata, cur_wdata);
      if (ar_hs) ar_seen = araddr;
      if (aw_hs) aw_seen = awaddr;
      if (w_hs)  w_seen = wdata;
      if (r_hs)  obs_q.push_back('{wr: 1'b0, addr: ar_seen, data: rdata});
      if (b_hs) begin
        slv_mem[aw_seen] = w_seen;
        obs_q.push_back('{wr: 1'b1, addr: aw_seen, data: w_seen});
      end
      #1;
      if (!reset) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_a = 0; r_a = 0; aw_a = 0; w_a = 0; b_a = 0;
      end else begin
        if (ar_hs) begin arready = 0; ar_a = 0; chk("arvalid_drop", arvalid, 0); end
        else if (ar_p) chk("arvalid_hold", arvalid, 1);
        if (aw_hs) begin awready = 0; aw_a = 0; chk("awvalid_drop", awvalid, 0); end
        else if (aw_p) chk("awvalid_hold", awvalid, 1);
        if (w_hs) begin wready = 0; w_a = 0; chk("wvalid_drop", wvalid, 0); end
        else if (w_p) chk("wvalid_hold", wvalid, 1);
        if (r_hs) begin rvalid = 0; r_a = 0; chk("rready_drop", rready, 0); end
        else if (r_p) chk("rready_hold", rready, 1);
        if (b_hs) begin bvalid = 0; b_a = 0; chk("bready_drop", bready, 0); end
        else if (b_p) chk("bready_hold", bready, 1);

        if (arvalid && !arready) begin
          if (!ar_a) begin ar_a = 1; ar_c = pick(ar_d); end
          if (ar_c == 0) arready = 1; else ar_c--;
        end
        if (awvalid && !awready) begin
          if (!aw_a) begin aw_a = 1; aw_c = pick(aw_d); end
          if (aw_c == 0) awready = 1; else aw_c--;
        end
        if (wvalid && !wready) begin
          if (!w_a) begin w_a = 1; w_c = pick(w_d); end
          if (w_c == 0) wready = 1; else w_c--;
        end
        if (!rvalid) rdata = $urandom;
        if (rready && !rvalid) begin
          if (!r_a) begin r_a = 1; r_c = pick(r_d); end
          if (r_c == 0) begin rvalid = 1; rdata = srd(ar_seen); end
          else r_c--;
        end
        if (bready && !bvalid) begin
          if (!b_a) begin b_a = 1; b_c = pick(b_d); end
          if (b_c == 0) bvalid = 1; else b_c--;
        end
      end
    end
  end

  initial begin : stim
    int n;
    reset = 0;
    axi_valid = 0;
    mem_wr_req = 0;
    mem_address = 0;
    mem_wdata = 0;
    ref_mem[32'h0000_1000] = 32'hDEAD_BEEF;
    slv_mem[32'h0000_1000] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Zero-wait read
    ar_d = 0; r_d = 0;
    do_req(0, 32'h0000_1000, 32'h0, 3);
    idle();
    // Write with both AW and W accepted after 3 wait cycles
    aw_d = 3; w_d = 3; b_d = 0;
    do_req(1, 32'h0000_2004, 32'h1234_5678, 6);
    idle();
    // W accepted first, then AW; then the reverse order
    aw_d = 3; w_d = 0;
    do_req(1, 32'h0000_2008, 32'hCAFE_0001, 6);
    idle();
    aw_d = 0; w_d = 3;
    do_req(1, 32'h0000_200C, 32'hCAFE_0002, 6);
    idle();
    // Slow write response, then slow read data
    aw_d = 0; w_d = 0; b_d = 4;
    do_req(1, 32'h0000_2010, 32'h0BAD_F00D, 7);
    idle();
    ar_d = 0; r_d = 2;
    do_req(0, 32'h0000_2004, 32'h0, 5);
    idle();

    // Abort a read while waiting in the data phase
    ar_d = 0; r_d = 30;
    mem_wr_req = 0;
    mem_address = 32'h0000_0080;
    cur_addr = 32'h0000_0080;
    axi_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rready && n < 50);
    if (!rready) fail("abort_reach_rdata");
    axi_valid = 0;
    #2 reset = 0;
    #1 chk_zero("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    last_rd = 0;
    ar_d = 0; r_d = 0;
    do_req(0, 32'h0000_0040, 32'h0, 3);
    idle();

    // Back-to-back random traffic
    ar_d = -1; r_d = -1; aw_d = -1; w_d = -1; b_d = -1;
    for (int i = 0; i < 20; i++) begin
      bit          wr;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      a  = 32'h0000_0100 + 32'(4 * $urandom_range(0, 7));
      do_req(wr, a, $urandom, -1);
    end
    idle();
    repeat (5) @(negedge clk);

    chk("pending_expected", exp_q.size(), 0);
    chk("pending_observed", obs_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
